// File: rtl/gram_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gram_write_arbiter_pkg
// Shared constants for the character GRAM write path: GRAM geometry, the
// visible text area size and the write-arbiter FSM state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package gram_write_arbiter_pkg;

   localparam int GRAM_ADDR_W = 12;
   localparam int GRAM_DATA_W = 7;
   localparam int TEXT_COLS   = 80;
   localparam int TEXT_ROWS   = 30;
   localparam int TEXT_DEPTH  = TEXT_COLS * TEXT_ROWS;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } gwa_state_e;

endpackage

// File: rtl/gram_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// gram_write_arbiter_if
// Bundles the write-side signals of the GRAM arbiter: clear control, the two
// request ports and the registered GRAM write port.
//   master : producers / test side (drives requests and clear control)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface gram_write_arbiter_if
   import gram_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = GRAM_ADDR_W,
   parameter int DATA_W = GRAM_DATA_W
);
   logic              clear_start;
   logic [DATA_W-1:0] clear_char;
   logic              clear_busy;
   logic              clear_done;

   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;

   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   logic              addr_err;

   logic [ADDR_W-1:0] gram_write_address;
   logic [DATA_W-1:0] gram_write_data;
   logic              gram_write_enable;

   modport master (
      output clear_start, clear_char,
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  clear_busy, clear_done, req0_ready, req1_ready, addr_err,
      input  gram_write_address, gram_write_data, gram_write_enable
   );

   modport slave (
      input  clear_start, clear_char,
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output clear_busy, clear_done, req0_ready, req1_ready, addr_err,
      output gram_write_address, gram_write_data, gram_write_enable
   );

endinterface

// File: rtl/gram_write_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. A lone requester is granted directly;
// when both request, the one not granted last wins. The history register
// only advances when the granted request is actually taken (i_accept).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid[1:0]   : requests
//   i_accept       : granted request was transferred this cycle
//   o_grant[1:0]   : one-hot grant (zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   // Reset to 1 so port 0 wins the first contended cycle.
   logic       r_last_grant;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      case (i_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_last_grant <= 1'b1;
      else if (i_accept) r_last_grant <= w_grant[1];
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/gram_write_arbiter.sv
// -----------------------------------------------------------------------------
// gram_write_arbiter
// Sole owner of the character GRAM write port. Shares it between two
// streaming requesters with round-robin arbitration and owns a clear engine
// that writes one character code to every visible cell.
//   i_clk   : system clock (CLOCK_50 domain)
//   i_rst_n : async active-low reset
//   bus     : slave side of gram_write_arbiter_if
//             clear_start/clear_char in, clear_busy/clear_done out,
//             req{0,1}_valid/addr/data in, req{0,1}_ready out (combinational),
//             addr_err out, gram_write_address/data/enable out (registered)
// -----------------------------------------------------------------------------
module gram_write_arbiter
   import gram_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = GRAM_ADDR_W,
   parameter int DATA_W = GRAM_DATA_W,
   parameter int DEPTH  = TEXT_DEPTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   gram_write_arbiter_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   gwa_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_clr_char;

   logic              r_we, r_err, r_busy, r_done;
   logic [ADDR_W-1:0] r_wa;
   logic [DATA_W-1:0] r_wd;

   logic              w_clr_wr, w_clr_last;
   logic [ADDR_W-1:0] w_clr_addr;
   logic [DATA_W-1:0] w_clr_data;

   logic [1:0]        w_grant;
   logic              w_open, w_xfer, w_addr_ok;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   // Ports are only open in IDLE and lose to a same-cycle clear request.
   assign w_open         = i_rst_n && (r_state == ST_IDLE) && !bus.clear_start;
   assign bus.req0_ready = w_open && w_grant[0];
   assign bus.req1_ready = w_open && w_grant[1];
   assign w_xfer         = (bus.req0_valid && bus.req0_ready) ||
                           (bus.req1_valid && bus.req1_ready);

   assign w_sel_addr = w_grant[1] ? bus.req1_addr : bus.req0_addr;
   assign w_sel_data = w_grant[1] ? bus.req1_data : bus.req0_data;
   assign w_addr_ok  = (w_sel_addr <= LAST_ADDR);

   rr_arbiter2 u_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid ({bus.req1_valid, bus.req0_valid}),
      .i_accept(w_xfer),
      .o_grant (w_grant)
   );

   // Clear engine: the start cycle itself issues address 0, every CLEAR
   // cycle issues r_cnt+1. Leaving CLEAR on the edge that issues the final
   // address lets a port be ready in the same cycle clear_done is visible,
   // while its write still lands one cycle after the last clear write.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_wr    = 1'b0;
      w_clr_addr  = '0;
      w_clr_data  = r_clr_char;
      case (r_state)
         ST_IDLE: begin
            if (bus.clear_start) begin
               w_clr_wr   = 1'b1;
               w_clr_data = bus.clear_char;
            end
         end
         ST_CLEAR: begin
            w_clr_wr   = 1'b1;
            w_clr_addr = r_cnt + 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_clr_last = w_clr_wr && (w_clr_addr == LAST_ADDR);
      if (w_clr_wr) w_state_nxt = w_clr_last ? ST_IDLE : ST_CLEAR;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Address/data hold their last value whenever no write is issued.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_clr_char <= '0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wa       <= '0;
         r_wd       <= '0;
      end else begin
         r_we   <= 1'b0;
         r_err  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         if (w_clr_wr) begin
            r_we   <= 1'b1;
            r_wa   <= w_clr_addr;
            r_wd   <= w_clr_data;
            r_busy <= 1'b1;
            r_done <= w_clr_last;
            r_cnt  <= w_clr_addr;
            if (r_state == ST_IDLE) r_clr_char <= bus.clear_char;
         end else if (w_xfer) begin
            // Out-of-range requests are consumed but never reach the GRAM.
            if (w_addr_ok) begin
               r_we <= 1'b1;
               r_wa <= w_sel_addr;
               r_wd <= w_sel_data;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign bus.gram_write_enable  = r_we;
   assign bus.gram_write_address = r_wa;
   assign bus.gram_write_data    = r_wd;
   assign bus.clear_busy         = r_busy;
   assign bus.clear_done         = r_done;
   assign bus.addr_err           = r_err;

endmodule
